// File: rtl/ir_nec_pkg.sv
// Shared NEC protocol definitions: the frame state machine encoding and the
// protocol durations in NEC units. The IR receiver uses these as well.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_t;

  localparam int unsigned NEC_LEAD_MARK_UNITS  = 16;
  localparam int unsigned NEC_LEAD_SPACE_UNITS = 8;
  localparam int unsigned NEC_BIT_MARK_UNITS   = 1;
  localparam int unsigned NEC_ZERO_SPACE_UNITS = 1;
  localparam int unsigned NEC_ONE_SPACE_UNITS  = 3;
  localparam int unsigned NEC_STOP_MARK_UNITS  = 1;
  localparam int unsigned NEC_FRAME_UNITS      = 192;

  // Length in units of a fixed-duration state; GAP is governed by frame spacing.
  function automatic int unsigned nec_state_units(nec_state_t s, logic bit_val);
    case (s)
      LEAD_MARK:  return NEC_LEAD_MARK_UNITS;
      LEAD_SPACE: return NEC_LEAD_SPACE_UNITS;
      BIT_MARK:   return NEC_BIT_MARK_UNITS;
      BIT_SPACE:  return bit_val ? NEC_ONE_SPACE_UNITS : NEC_ZERO_SPACE_UNITS;
      STOP_MARK:  return NEC_STOP_MARK_UNITS;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// ir_carrier_gen: 50% duty carrier from a modulo-CARRIER_DIV counter.
// Holding restart keeps the counter at 0 so each mark starts on a high half.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned CARRIER_DIV = 1316
) (
  input  logic clk_50,
  input  logic reset,
  input  logic restart,
  output logic carrier_high
);

  localparam int unsigned CNT_W = $clog2(CARRIER_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CARRIER_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CARRIER_DIV / 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb carrier_high = (cnt < CNT_HALF);

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: sends one 32-bit address/command frame per start
// as an envelope (ir_env) and a carrier-modulated LED drive (ir_tx).
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 28125,
  parameter int unsigned CARRIER_DIV = 1316,
  parameter int unsigned FRAME_UNITS = NEC_FRAME_UNITS
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_tx
);

  localparam int unsigned UNIT_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned FRAME_W = (FRAME_UNITS > 1) ? $clog2(FRAME_UNITS) : 1;
  localparam logic [UNIT_W-1:0]  UNIT_LAST  = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_UNITS - 1);

  nec_state_t         state;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [FRAME_W-1:0] frame_units;
  logic [3:0]         state_units;
  logic [5:0]         bit_idx;
  logic [31:0]        frame;

  logic       unit_tick;
  logic       frame_full;
  logic       cur_bit;
  logic [3:0] state_last;
  logic       carrier_restart;
  logic       carrier_high;

  always_comb begin
    unit_tick       = (unit_cnt == UNIT_LAST);
    frame_full      = (frame_units == FRAME_LAST);
    cur_bit         = frame[bit_idx[4:0]];
    state_last      = 4'(nec_state_units(state, cur_bit) - 1);
    // Marks never follow marks, so holding the carrier in restart during
    // spaces makes it start from count 0 on every mark entry.
    carrier_restart = ~ir_env;
  end

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier_gen (
    .clk_50      (clk_50),
    .reset       (reset),
    .restart     (carrier_restart),
    .carrier_high(carrier_high)
  );

  assign ir_tx = ir_env & carrier_high;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      unit_cnt    <= '0;
      frame_units <= '0;
      state_units <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ir_env      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done) begin
          frame       <= {~command, command, ~address, address};
          state       <= LEAD_MARK;
          busy        <= 1'b1;
          ir_env      <= 1'b1;
          unit_cnt    <= '0;
          frame_units <= '0;
          state_units <= '0;
          bit_idx     <= '0;
        end
      end else if (!unit_tick) begin
        unit_cnt <= unit_cnt + UNIT_W'(1);
      end else begin
        unit_cnt    <= '0;
        state_units <= state_units + 4'd1;
        if (!frame_full) begin
          frame_units <= frame_units + FRAME_W'(1);
        end
        if (state == GAP) begin
          // frame_units saturates, so GAP always spans at least one unit.
          if (frame_full) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else if (state_units == state_last) begin
          state_units <= '0;
          case (state)
            LEAD_MARK: begin
              state  <= LEAD_SPACE;
              ir_env <= 1'b0;
            end
            LEAD_SPACE: begin
              state  <= BIT_MARK;
              ir_env <= 1'b1;
            end
            BIT_MARK: begin
              state  <= BIT_SPACE;
              ir_env <= 1'b0;
            end
            BIT_SPACE: begin
              ir_env <= 1'b1;
              if (bit_idx == 6'd31) begin
                state <= STOP_MARK;
              end else begin
                bit_idx <= bit_idx + 6'd1;
                state   <= BIT_MARK;
              end
            end
            STOP_MARK: begin
              state  <= GAP;
              ir_env <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              busy   <= 1'b0;
              ir_env <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: expected envelope/LED waveforms are rebuilt per frame
// from the NEC segment rules and compared cycle by cycle with the DUT.
module tb_ir_nec_tx;

  localparam int unsigned UC        = 4;
  localparam int unsigned CD        = 4;
  localparam int unsigned FU        = 192;
  localparam int          FRAME_CYC = FU * UC;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] command = '0;
  logic       busy, done, ir_env, ir_tx;

  int checks = 0;
  int errors = 0;

  ir_nec_tx #(
    .UNIT_CYCLES(UC),
    .CARRIER_DIV(CD),
    .FRAME_UNITS(FU)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .start  (start),
    .address(address),
    .command(command),
    .busy   (busy),
    .done   (done),
    .ir_env (ir_env),
    .ir_tx  (ir_tx)
  );

  always #5 clk_50 = ~clk_50;

  logic        exp_env[$];
  logic        exp_tx[$];
  logic        cap_env[$];
  logic        cap_tx[$];
  logic [31:0] exp_word;
  int          cap_busy;
  int          cap_idle;
  int          cap_done_idx;

  // Reference: a frame is a list of (level, units) segments padded with
  // space to FU units; the carrier phase restarts at every segment.
  function automatic void add_seg(input logic lvl, input int unsigned units);
    for (int unsigned k = 0; k < units * UC; k++) begin
      exp_env.push_back(lvl);
      exp_tx.push_back(lvl && ((k % CD) < CD / 2));
    end
  endfunction

  function automatic void build_model(input logic [7:0] a, input logic [7:0] c);
    exp_env.delete();
    exp_tx.delete();
    exp_word = {~c, c, ~a, a};
    add_seg(1'b1, 16);
    add_seg(1'b0, 8);
    for (int b = 0; b < 32; b++) begin
      add_seg(1'b1, 1);
      add_seg(1'b0, exp_word[b] ? 3 : 1);
    end
    add_seg(1'b1, 1);
    while (exp_env.size() < FRAME_CYC) begin
      exp_env.push_back(1'b0);
      exp_tx.push_back(1'b0);
    end
  endfunction

  function automatic int env_diffs();
    int n = (cap_env.size() != exp_env.size()) ? 1 : 0;
    for (int i = 0; i < cap_env.size() && i < exp_env.size(); i++)
      if (cap_env[i] !== exp_env[i]) n++;
    return n;
  endfunction

  function automatic int tx_diffs();
    int n = (cap_tx.size() != exp_tx.size()) ? 1 : 0;
    for (int i = 0; i < cap_tx.size() && i < exp_tx.size(); i++)
      if (cap_tx[i] !== exp_tx[i]) n++;
    return n;
  endfunction

  // Decode the captured envelope: run 3+2b is the space following bit b's mark.
  function automatic logic [31:0] decode_word();
    int          runs[$];
    int          len = 0;
    logic        cur = 1'b1;
    logic [31:0] w = '0;
    for (int j = 0; j < cap_env.size(); j++) begin
      if (j == 0) begin
        cur = cap_env[0];
        len = 1;
      end else if (cap_env[j] === cur) begin
        len++;
      end else begin
        runs.push_back(len);
        cur = cap_env[j];
        len = 1;
      end
    end
    runs.push_back(len);
    for (int b = 0; b < 32; b++)
      if (3 + 2 * b < runs.size()) w[b] = (runs[3 + 2 * b] > 2 * UC);
    return w;
  endfunction

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] c);
    @(negedge clk_50);
    address = a;
    command = c;
    start   = 1'b1;
    @(negedge clk_50);
    start   = 1'b0;
  endtask

  // Called in the first LEAD_MARK cycle; returns in the done cycle (or on timeout).
  task automatic capture(input int inject_at);
    cap_env.delete();
    cap_tx.delete();
    cap_busy     = 0;
    cap_idle     = 0;
    cap_done_idx = -1;
    for (int i = 0; i < FRAME_CYC + 200; i++) begin
      if (i > 0) @(negedge clk_50);
      start = (i == inject_at);
      if (i == inject_at) begin
        address = 8'($urandom);
        command = 8'($urandom);
      end
      if (done === 1'b1) begin
        cap_done_idx = i;
        break;
      end
      if (busy === 1'b1) begin
        cap_env.push_back(ir_env);
        cap_tx.push_back(ir_tx);
        cap_busy++;
      end else begin
        cap_idle++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, ir_env, ir_tx} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000", {busy, done, ir_env, ir_tx});
    end
    @(negedge clk_50);
    reset = 1'b0;
    repeat (4) @(negedge clk_50);
    checks++;
    if ({busy, ir_env} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy/env got %b want 00", {busy, ir_env});
    end
  endtask

  task automatic test_zero_frame();
    build_model(8'h00, 8'h00);
    pulse_start(8'h00, 8'h00);
    capture(-1);
    checks++;
    if (cap_done_idx !== FRAME_CYC) begin
      errors++;
      $display("FAIL zero_done_idx: got %0d want %0d", cap_done_idx, FRAME_CYC);
    end
    checks++;
    if (cap_busy !== FRAME_CYC || cap_idle !== 0) begin
      errors++;
      $display("FAIL zero_busy_len: got %0d (idle %0d) want %0d", cap_busy, cap_idle, FRAME_CYC);
    end
    checks++;
    if (env_diffs() !== 0) begin
      errors++;
      $display("FAIL zero_env: got %0d differing cycles want 0", env_diffs());
    end
    checks++;
    if (tx_diffs() !== 0) begin
      errors++;
      $display("FAIL zero_tx: got %0d differing cycles want 0", tx_diffs());
    end
    @(negedge clk_50);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_done_single: done/busy got %b want 00", {done, busy});
    end
  endtask

  task automatic test_decode();
    build_model(8'hA5, 8'h3C);
    pulse_start(8'hA5, 8'h3C);
    capture(-1);
    checks++;
    if (decode_word() !== 32'hC33C5AA5) begin
      errors++;
      $display("FAIL decode_a5_3c: got %h want c33c5aa5", decode_word());
    end
    checks++;
    if (env_diffs() !== 0 || tx_diffs() !== 0) begin
      errors++;
      $display("FAIL decode_wave: got env %0d tx %0d diffs want 0", env_diffs(), tx_diffs());
    end
  endtask

  task automatic test_all_ones();
    int last_mark = -1;
    build_model(8'hFF, 8'hFF);
    pulse_start(8'hFF, 8'hFF);
    capture(-1);
    for (int i = 0; i < cap_env.size(); i++)
      if (cap_env[i] === 1'b1) last_mark = i;
    checks++;
    if (last_mark < 0 || last_mark >= FRAME_CYC - int'(UC)) begin
      errors++;
      $display("FAIL ones_env_len: got last mark %0d want < %0d", last_mark, FRAME_CYC - int'(UC));
    end
    checks++;
    if (cap_done_idx !== FRAME_CYC || cap_busy !== FRAME_CYC) begin
      errors++;
      $display("FAIL ones_busy_len: got %0d/%0d want %0d", cap_busy, cap_done_idx, FRAME_CYC);
    end
    checks++;
    if (env_diffs() !== 0 || tx_diffs() !== 0) begin
      errors++;
      $display("FAIL ones_wave: got env %0d tx %0d diffs want 0", env_diffs(), tx_diffs());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1 = 8'($urandom), c1 = 8'($urandom);
    logic [7:0] a2 = 8'($urandom), c2 = 8'($urandom);
    build_model(a1, c1);
    pulse_start(a1, c1);
    capture(100);
    checks++;
    if (env_diffs() !== 0 || tx_diffs() !== 0 || cap_done_idx !== FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_inflight: got env %0d tx %0d diffs done@%0d want 0 0 %0d",
               env_diffs(), tx_diffs(), cap_done_idx, FRAME_CYC);
    end
    checks++;
    if (decode_word() !== exp_word) begin
      errors++;
      $display("FAIL b2b_word1: got %h want %h", decode_word(), exp_word);
    end
    address = a2;
    command = c2;
    start   = 1'b1;
    @(negedge clk_50);
    checks++;
    if ({busy, ir_env} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_done_start: busy/env got %b want 00", {busy, ir_env});
    end
    @(negedge clk_50);
    start = 1'b0;
    build_model(a2, c2);
    capture(-1);
    checks++;
    if (env_diffs() !== 0 || tx_diffs() !== 0 || cap_done_idx !== FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_second: got env %0d tx %0d diffs done@%0d want 0 0 %0d",
               env_diffs(), tx_diffs(), cap_done_idx, FRAME_CYC);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a = 8'($urandom), c = 8'($urandom);
    logic       done_seen = 1'b0;
    build_model(a, c);
    pulse_start(a, c);
    repeat (300) @(negedge clk_50);
    checks++;
    if (busy !== 1'b1 || ir_env !== exp_env[300]) begin
      errors++;
      $display("FAIL mid_pre_reset: busy/env got %b%b want 1%b", busy, ir_env, exp_env[300]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, ir_env, ir_tx} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_reset: got %b want 0000", {busy, done, ir_env, ir_tx});
    end
    repeat (3) begin
      @(negedge clk_50);
      if (done !== 1'b0) done_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk_50);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: got activity %b want 0", done_seen);
    end
    a = 8'($urandom);
    c = 8'($urandom);
    build_model(a, c);
    pulse_start(a, c);
    capture(-1);
    checks++;
    if (env_diffs() !== 0 || tx_diffs() !== 0 || cap_done_idx !== FRAME_CYC) begin
      errors++;
      $display("FAIL mid_after_reset: got env %0d tx %0d diffs done@%0d want 0 0 %0d",
               env_diffs(), tx_diffs(), cap_done_idx, FRAME_CYC);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] a = 8'($urandom), c = 8'($urandom);
      build_model(a, c);
      pulse_start(a, c);
      capture(-1);
      checks++;
      if (decode_word() !== exp_word) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %h want %h", n, decode_word(), exp_word);
      end
      checks++;
      if (env_diffs() !== 0 || tx_diffs() !== 0 || cap_done_idx !== FRAME_CYC) begin
        errors++;
        $display("FAIL rand_wave[%0d]: got env %0d tx %0d diffs done@%0d want 0 0 %0d",
                 n, env_diffs(), tx_diffs(), cap_done_idx, FRAME_CYC);
      end
      repeat (int'($urandom_range(1, 5))) @(negedge clk_50);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_decode();
    test_all_ones();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
